sa_core_param: RTL
==================

Name: sa_core_param

Overview:
Parametrised output-stationary systolic matrix-multiply core, ROWS x COLS signed MAC PEs. Accepts one K-slice per beat (column of A, row of B) over a valid/ready handshake, skews operands internally, and accumulates C = A x B. It then drains C row-major through the r_read/rout/rvalid read port. This block succeeds the fixed-size core, adding run-time K length, input backpressure, an rlast marker and optional saturation.

Parameters:
ROWS, 4, PE array rows (>=1)
COLS, 4, PE array columns (>=1)
DATA_W, 8, signed operand width
ACC_W, 32, signed accumulator/result width (>= 2*DATA_W)
K_W, 16, width of k_len
SATURATE, 0, 1 = accumulators clamp at signed ACC_W limits; 0 = two's-complement wrap

Ports:
clk  in  1  clock
rst  in  1  async reset, active-high
fire  in  1  start tile; sampled only in IDLE
k_len  in  K_W  beats in tile; latched on accepted fire
in_valid  in  1  operand beat valid
in_ready  out  1  core accepts operand beat
a_vec  in  ROWS*DATA_W  A[i][k] for all i; slice i = bits [i*DATA_W +: DATA_W]
b_vec  in  COLS*DATA_W  B[k][j] for all j; same slicing
r_read  in  1  consume current result
rout  out  ACC_W  current result C[i][j]
rvalid  out  1  rout holds valid result
rlast  out  1  rout is C[ROWS-1][COLS-1]
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready, rvalid, rlast, busy = 0; rout = 0; all accumulators, skew registers, valid tags and counters = 0.
- FSM states:
  - IDLE:
    - fire=1 with k_len!=0: latch k_len, clear all accumulators, go to FEED.
    - fire with k_len==0: ignored, stay IDLE.
  - FEED:
    - in_ready=1. A beat is accepted on in_valid&&in_ready; the beat counter increments.
    - On the accepted beat where count==k_len-1: go to FLUSH (in_ready=0 next cycle).
    - in_valid low inserts a bubble (valid tag 0); results are unaffected.
  - FLUSH: in_ready=0. Run exactly ROWS+COLS cycles so the last tagged operands reach PE(ROWS-1,COLS-1), then go to DRAIN.
  - DRAIN:
    - rvalid=1; rout = C[idx], idx row-major (i*COLS+j) starting at 0.
    - r_read&&rvalid advances idx the next cycle.
    - rlast=1 when idx==ROWS*COLS-1. Reading it returns to IDLE (rvalid=0 next cycle).
    - r_read while rvalid=0 is ignored.
- fire outside IDLE is ignored. Any rst assertion mid-tile aborts to reset values and discards partial results.
- Skew and dataflow:
  - Row i of A is delayed i cycles and column j of B is delayed j cycles, each with a 1-bit valid tag.
  - Each PE registers a (passes right) and b (passes down) with its tags, one cycle per hop.
  - PE(i,j) sees beat k's operands together, i+j+1 cycles after acceptance.
- PE accumulate:
  - Accumulates only when both incoming tags are 1: acc += sext(a*b), where a*b is a full 2*DATA_W signed product.
  - SATURATE=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1], sticky within the add (each add clamps from the current value).
  - SATURATE=0: wrap mod 2^ACC_W.
- Latency: with back-to-back beats and no bubbles, rvalid rises k_len+ROWS+COLS+1 cycles after fire.
- Results stay stable while rvalid=1 and r_read=0 (read backpressure of any length).

Decomposition:
- Package sa_pkg: state enum {IDLE, FEED, FLUSH, DRAIN}; sat-add function parametrised by ACC_W; localparams for index widths (clog2 of ROWS*COLS, ROWS+COLS).
- One sub-module, sa_pe: operand/tag pass-through registers plus accumulator with clear and SATURATE. It is instantiated via nested generate.
- Skew delay lines and FSM stay in sa_core_param.

Test Plan:
1. ROWS=COLS=2, DATA_W=8, K=2:
   - Stimulus: A=[[1,2],[3,4]], B=[[5,6],[7,8]], back-to-back beats.
   - Response: rout sequence 19,22,43,50; rlast only on 50; rvalid first high exactly 2+2+2+1=7 cycles after fire.
2. Same data, in_valid dropped 3 cycles between beats, and r_read held low 5 cycles mid-drain → identical results. rout holds 22 while stalled.
3. ACC_W=16, all operands 127, K=3 (sum 48387):
   - SATURATE=1 → every result 32767.
   - SATURATE=0 → every result -17149.
   - Operands -128 x 127, K=3, SATURATE=1 → -32768.
4. Control guards:
   - fire with k_len=0 → stays IDLE, busy=0.
   - fire pulsed during FEED and DRAIN → no restart; tile count and results unchanged.
5. Reset mid-DRAIN after 1 read: rst asserted → same cycle rvalid=0, busy=0, in_ready=0. A new tile with A=I, B=[[9,8],[7,6]] then yields 9,8,7,6 (no residue from the old tile).
6. ROWS=3, COLS=2, K=4, random signed operands vs golden model → all 6 results match in row-major order; in_ready high for exactly the 4 accepted beats.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and helpers for the parametrised systolic matrix-multiply core.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Counter width able to hold 0..n-1 (never narrower than one bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Accumulator add at an arbitrary result width (up to 62 bits). With sat
  // set the sum clamps to the signed limits of that width; otherwise the
  // caller keeps only the low bits, which gives two's-complement wrap.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] acc,
                                                 input logic signed [63:0] inc,
                                                 input int                 width,
                                                 input bit                 sat);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = acc + inc;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sat && (sum > hi)) return hi;
    if (sat && (sum < lo)) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/sa_core_param_pe.sv
// One systolic processing element: registers the operands and tags that pass
// right/down, and accumulates their product when both tags are set.
module sa_pe
  import sa_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_tag_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_tag_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_tag_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_tag_out,
  output logic [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;

  // Full-width signed product of the operands currently held in this PE.
  always_comb begin
    prod = $signed(a_out) * $signed(b_out);
  end

  // Operand hop registers and the accumulator.
  // NOTE: sequential state uses non-blocking assignments so every PE samples
  // its neighbour's pre-edge value; blocking here would collapse the hops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out     <= '0;
      a_tag_out <= 1'b0;
      b_out     <= '0;
      b_tag_out <= 1'b0;
      acc       <= '0;
    end else begin
      a_out     <= a_in;
      a_tag_out <= a_tag_in;
      b_out     <= b_in;
      b_tag_out <= b_tag_in;
      if (clr) begin
        acc <= '0;
      end else if (a_tag_out && b_tag_out) begin
        acc <= ACC_W'(sat_add(64'($signed(acc)), 64'(prod), ACC_W, SATURATE != 0));
      end
    end
  end

endmodule

// File: rtl/sa_core_param.sv
// Output-stationary ROWS x COLS systolic matrix-multiply core: takes K operand
// beats, skews them into the PE grid, then drains C row-major.
module sa_core_param
  import sa_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int K_W      = 16,
  parameter int SATURATE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fire,
  input  logic [K_W-1:0]         k_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] a_vec,
  input  logic [COLS*DATA_W-1:0] b_vec,
  input  logic                   r_read,
  output logic [ACC_W-1:0]       rout,
  output logic                   rvalid,
  output logic                   rlast,
  output logic                   busy
);

  localparam int NRES  = ROWS * COLS;
  localparam int IDX_W = idx_w(NRES);
  localparam int FL_W  = idx_w(ROWS + COLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NRES - 1);
  localparam logic [FL_W-1:0]  LAST_FL  = FL_W'(ROWS + COLS - 1);

  state_t           state_q, state_d;
  logic [K_W-1:0]   k_len_q, beat_q;
  logic [FL_W-1:0]  flush_q;
  logic [IDX_W-1:0] idx_q;
  logic             start, accept;

  logic [DATA_W-1:0] skew_a  [ROWS];
  logic              skew_at [ROWS];
  logic [DATA_W-1:0] skew_b  [COLS];
  logic              skew_bt [COLS];

  logic [DATA_W-1:0] a_link  [ROWS][COLS];
  logic              at_link [ROWS][COLS];
  logic [DATA_W-1:0] b_link  [ROWS][COLS];
  logic              bt_link [ROWS][COLS];
  logic [ACC_W-1:0]  acc_flat [NRES];

  // Next-state logic: tile start, last beat, flush length, last read.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    start   = (state_q == IDLE) && fire && (k_len != '0);
    accept  = (state_q == FEED) && in_valid;
    case (state_q)
      IDLE:  if (start) state_d = FEED;
      FEED:  if (accept && (beat_q == k_len_q - K_W'(1))) state_d = FLUSH;
      FLUSH: if (flush_q == LAST_FL) state_d = DRAIN;
      DRAIN: if (r_read && (idx_q == LAST_IDX)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Beat, flush and read-index counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_len_q <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      idx_q   <= '0;
    end else begin
      if (start) begin
        k_len_q <= k_len;
        beat_q  <= '0;
      end else if (accept) begin
        beat_q <= beat_q + K_W'(1);
      end
      flush_q <= (state_q == FLUSH) ? flush_q + FL_W'(1) : '0;
      if (state_q != DRAIN) idx_q <= '0;
      else if (r_read)      idx_q <= idx_q + IDX_W'(1);
    end
  end

  // Row 0 and column 0 enter the grid undelayed.
  assign skew_a[0]  = a_vec[0 +: DATA_W];
  assign skew_at[0] = accept;
  assign skew_b[0]  = b_vec[0 +: DATA_W];
  assign skew_bt[0] = accept;

  for (genvar gi = 1; gi < ROWS; gi++) begin : g_skew_a
    logic [DATA_W-1:0] dl [gi];
    logic              tl [gi];
    // Delay row gi of A by gi cycles, tag alongside.
    // NOTE: the delay-line arrays are reset element by element so a reset
    // mid-tile cannot leave stale tagged operands in flight.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < gi; k++) begin
          dl[k] <= '0;
          tl[k] <= 1'b0;
        end
      end else begin
        dl[0] <= a_vec[gi*DATA_W +: DATA_W];
        tl[0] <= accept;
        for (int k = 1; k < gi; k++) begin
          dl[k] <= dl[k-1];
          tl[k] <= tl[k-1];
        end
      end
    end
    assign skew_a[gi]  = dl[gi-1];
    assign skew_at[gi] = tl[gi-1];
  end

  for (genvar gj = 1; gj < COLS; gj++) begin : g_skew_b
    logic [DATA_W-1:0] dl [gj];
    logic              tl [gj];
    // Delay column gj of B by gj cycles, tag alongside.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < gj; k++) begin
          dl[k] <= '0;
          tl[k] <= 1'b0;
        end
      end else begin
        dl[0] <= b_vec[gj*DATA_W +: DATA_W];
        tl[0] <= accept;
        for (int k = 1; k < gj; k++) begin
          dl[k] <= dl[k-1];
          tl[k] <= tl[k-1];
        end
      end
    end
    assign skew_b[gj]  = dl[gj-1];
    assign skew_bt[gj] = tl[gj-1];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [DATA_W-1:0] a_src, b_src;
      logic              at_src, bt_src;
      if (c == 0) begin : g_a_edge
        assign a_src  = skew_a[r];
        assign at_src = skew_at[r];
      end else begin : g_a_link
        assign a_src  = a_link[r][c-1];
        assign at_src = at_link[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_src  = skew_b[c];
        assign bt_src = skew_bt[c];
      end else begin : g_b_link
        assign b_src  = b_link[r-1][c];
        assign bt_src = bt_link[r-1][c];
      end
      sa_pe #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .SATURATE(SATURATE)
      ) u_pe (
        .clk      (clk),
        .rst      (rst),
        .clr      (start),
        .a_in     (a_src),
        .a_tag_in (at_src),
        .b_in     (b_src),
        .b_tag_in (bt_src),
        .a_out    (a_link[r][c]),
        .a_tag_out(at_link[r][c]),
        .b_out    (b_link[r][c]),
        .b_tag_out(bt_link[r][c]),
        .acc      (acc_flat[r*COLS+c])
      );
    end
  end

  assign in_ready = (state_q == FEED);
  assign busy     = (state_q != IDLE);
  assign rvalid   = (state_q == DRAIN);
  assign rlast    = rvalid && (idx_q == LAST_IDX);
  assign rout     = rvalid ? acc_flat[idx_q] : '0;

endmodule
